// File: rtl/mem_if_pkg.sv
// mem_if_pkg: constants and types shared by the cache controller and the line memory controller.
//   LINE_W / OFFSET_BITS : line width and dropped low address bits, identical on both sides of the bus
//   RW_READ / RW_WRITE   : encoding of mem_req_rw
//   state_t              : line memory controller FSM states
package mem_if_pkg;
    localparam int LINE_W      = 512;
    localparam int OFFSET_BITS = 4;
    localparam logic RW_READ   = 1'b0;
    localparam logic RW_WRITE  = 1'b1;
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESPOND} state_t;
endpackage

// File: rtl/line_memory_ctrl_if.sv
// line_memory_ctrl_if: cache <-> main memory line request bus.
//   master (cache side) : drives mem_req_enable/rw/addr/dataout, observes datain/ready/busy/req_dropped/addr_err
//   slave (memory side) : the reverse
interface line_memory_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = mem_if_pkg::LINE_W
);
    logic              mem_req_enable;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LINE_W-1:0] mem_req_dataout;
    logic [LINE_W-1:0] mem_req_datain;
    logic              mem_req_ready;
    logic              busy;
    logic              req_dropped;
    logic              addr_err;
    modport master (
        output mem_req_enable, mem_req_rw, mem_req_addr, mem_req_dataout,
        input  mem_req_datain, mem_req_ready, busy, req_dropped, addr_err
    );
    modport slave (
        input  mem_req_enable, mem_req_rw, mem_req_addr, mem_req_dataout,
        output mem_req_datain, mem_req_ready, busy, req_dropped, addr_err
    );
endinterface

// File: rtl/line_memory_ctrl_store.sv
// line_store: single-port LINE_W x 2**IDX_W synchronous RAM, no reset, so a technology macro can replace it.
//   clk     : clock
//   i_en    : access enable for this edge
//   i_we    : 1 = write i_wdata to i_addr, 0 = read i_addr into o_rdata
//   i_addr  : line index
//   i_wdata : write data
//   o_rdata : read data, updated only by reads
module line_store #(
    parameter int LINE_W = 512,
    parameter int IDX_W  = 10
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] o_rdata
);
    logic [LINE_W-1:0] r_mem [2**IDX_W];
    logic [LINE_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) r_mem[i_addr] <= i_wdata;
            else      r_rdata       <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/line_memory_ctrl.sv
// line_memory_ctrl: main-memory side of the cache; services line reads/writes with a fixed latency.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (store contents are not reset)
//   bus   : slave side of line_memory_ctrl_if (request strobe, rw, address, data, ready/busy/status pulses)
module line_memory_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = mem_if_pkg::LINE_W,
    parameter int OFFSET_BITS = mem_if_pkg::OFFSET_BITS,
    parameter int IDX_W       = 10,
    parameter int RD_LAT      = 8,
    parameter int WR_LAT      = 8
) (
    input logic                clk,
    input logic                rst_n,
    line_memory_ctrl_if.slave  bus
);
    import mem_if_pkg::*;

    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam int TOP_LO  = OFFSET_BITS + IDX_W;

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rw, r_err, r_dropped, r_rd_valid;
    logic [IDX_W-1:0]  r_idx;
    logic [LINE_W-1:0] r_wdata, w_rdata;
    logic              w_accept, w_commit, w_unused_lo;

    // The store access happens on the edge that enters RESPOND.
    assign w_commit    = r_state == ST_BUSY && r_cnt == '0;
    assign w_accept    = bus.mem_req_enable && r_state != ST_BUSY;
    assign w_unused_lo = ^bus.mem_req_addr[OFFSET_BITS-1:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    w_next = bus.mem_req_enable ? ST_BUSY : ST_IDLE;
            ST_BUSY:    w_next = (r_cnt == '0) ? ST_RESPOND : ST_BUSY;
            ST_RESPOND: w_next = bus.mem_req_enable ? ST_BUSY : ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rw       <= RW_READ;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
            r_dropped  <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_dropped <= r_state == ST_BUSY && bus.mem_req_enable;
            if (w_accept) begin
                r_rw    <= bus.mem_req_rw;
                r_idx   <= bus.mem_req_addr[TOP_LO-1:OFFSET_BITS];
                r_wdata <= bus.mem_req_dataout;
                r_err   <= |bus.mem_req_addr[ADDR_W-1:TOP_LO];
                r_cnt   <= (bus.mem_req_rw == RW_WRITE) ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);
            end else if (r_state == ST_BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            // The RAM output is unreset; datain reads as zero until a read has completed since reset.
            if (w_commit && r_rw == RW_READ) r_rd_valid <= 1'b1;
        end
    end

    line_store #(.LINE_W(LINE_W), .IDX_W(IDX_W)) u_store (
        .clk     (clk),
        .i_en    (w_commit),
        .i_we    (r_rw == RW_WRITE),
        .i_addr  (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    assign bus.mem_req_datain = r_rd_valid ? w_rdata : '0;
    assign bus.mem_req_ready  = r_state == ST_RESPOND;
    assign bus.busy           = r_state != ST_IDLE;
    assign bus.req_dropped    = r_dropped;
    assign bus.addr_err       = r_state == ST_RESPOND && r_err;
endmodule
